ps2_key_decoder: RTL

- Downstream of the PS/2 serial receiver, which emits one set-2 scan-code byte per frame.
- Runs in the system clock domain. Parses make, break (F0) and extended (E0) sequences and tracks Shift.
- Translates make codes to ASCII and buffers the characters in a small FIFO that the processor drains through a read strobe.

---
 rtl/ps2_key_decoder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code parser with Shift tracking, ASCII translation and a pop-on-read FIFO.
// Defining KB_CAPS_LOCK_EN adds a Caps Lock toggle (code 58) and the Caps_State output.
module ps2_key_decoder #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Code_Byte,
    input  logic       Code_Valid,
    input  logic       Rd_En,
    output logic [7:0] Rd_Data,
    output logic       Empty,
    output logic       Full,
    output logic       Overflow,
    input  logic       Ovf_Clr,
`ifdef KB_CAPS_LOCK_EN
    output logic       Caps_State,
`endif
    output logic       Shift_State
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BRK     = 2'd1;
    localparam logic [1:0] EXT     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [1:0]    state_q, state_d;
    logic          shift_q, shift_d;
    logic          caps_q, caps_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];

    logic [7:0] base_char, xlat, push_char;
    logic       upper, is_letter, is_digit, ignored;
    logic       push_req, do_push, pop;

    // Unshifted character for each supported make code.
    always_comb begin
        base_char = 8'h00;
        case (Code_Byte)
            8'h1C: base_char = 8'h61;  8'h32: base_char = 8'h62;  8'h21: base_char = 8'h63;
            8'h23: base_char = 8'h64;  8'h24: base_char = 8'h65;  8'h2B: base_char = 8'h66;
            8'h34: base_char = 8'h67;  8'h33: base_char = 8'h68;  8'h43: base_char = 8'h69;
            8'h3B: base_char = 8'h6A;  8'h42: base_char = 8'h6B;  8'h4B: base_char = 8'h6C;
            8'h3A: base_char = 8'h6D;  8'h31: base_char = 8'h6E;  8'h44: base_char = 8'h6F;
            8'h4D: base_char = 8'h70;  8'h15: base_char = 8'h71;  8'h2D: base_char = 8'h72;
            8'h1B: base_char = 8'h73;  8'h2C: base_char = 8'h74;  8'h3C: base_char = 8'h75;
            8'h2A: base_char = 8'h76;  8'h1D: base_char = 8'h77;  8'h22: base_char = 8'h78;
            8'h35: base_char = 8'h79;  8'h1A: base_char = 8'h7A;
            8'h45: base_char = 8'h30;  8'h16: base_char = 8'h31;  8'h1E: base_char = 8'h32;
            8'h26: base_char = 8'h33;  8'h25: base_char = 8'h34;  8'h2E: base_char = 8'h35;
            8'h36: base_char = 8'h36;  8'h3D: base_char = 8'h37;  8'h3E: base_char = 8'h38;
            8'h46: base_char = 8'h39;
            8'h29: base_char = 8'h20;  8'h5A: base_char = 8'h0D;
            8'h66: base_char = 8'h08;  8'h76: base_char = 8'h1B;
            default: base_char = 8'h00;
        endcase
    end

    assign is_letter = (base_char >= 8'h61) && (base_char <= 8'h7A);
    assign is_digit  = (base_char >= 8'h30) && (base_char <= 8'h39);
`ifdef KB_CAPS_LOCK_EN
    assign upper = shift_q ^ caps_q;
`else
    assign upper = shift_q;
`endif

    always_comb begin
        xlat = base_char;
        if (is_letter && upper) begin
            xlat = base_char - 8'h20;
        end else if (is_digit && shift_q) begin
            case (base_char)
                8'h30: xlat = 8'h29;  8'h31: xlat = 8'h21;  8'h32: xlat = 8'h40;
                8'h33: xlat = 8'h23;  8'h34: xlat = 8'h24;  8'h35: xlat = 8'h25;
                8'h36: xlat = 8'h5E;  8'h37: xlat = 8'h26;  8'h38: xlat = 8'h2A;
                default: xlat = 8'h28;
            endcase
        end
    end

    assign ignored = (Code_Byte == 8'hFA) || (Code_Byte == 8'hAA) || (Code_Byte == 8'hEE) ||
                     (Code_Byte == 8'hFE) || (Code_Byte == 8'h00) || (Code_Byte == 8'hFF);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        caps_d   = caps_q;
        push_req = 1'b0;
        if (Code_Valid) begin
            case (state_q)
                IDLE: begin
                    if (Code_Byte == 8'hF0) begin
                        state_d = BRK;
                    end else if (Code_Byte == 8'hE0) begin
                        state_d = EXT;
                    end else if (ignored) begin
                        state_d = IDLE;
                    end else if ((Code_Byte == 8'h12) || (Code_Byte == 8'h59)) begin
                        shift_d = 1'b1;
`ifdef KB_CAPS_LOCK_EN
                    end else if (Code_Byte == 8'h58) begin
                        caps_d = ~caps_q;
`endif
                    end else begin
                        push_req = (xlat != 8'h00);
                    end
                end
                BRK: begin
                    if ((Code_Byte == 8'h12) || (Code_Byte == 8'h59)) shift_d = 1'b0;
                    state_d = IDLE;
                end
                EXT: begin
                    if (Code_Byte == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        push_req = (Code_Byte == 8'h5A);
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign push_char = (state_q == EXT) ? 8'h0D : xlat;

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign pop     = Rd_En && (count_q != '0);
    assign do_push = push_req && ((count_q != FULL_CNT) || pop);

    always_comb begin
        wr_ptr_d  = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        rd_data_d = pop ? mem_q[rd_ptr_q] : rd_data_q;
        count_d   = count_q;
        if (do_push && !pop) count_d = count_q + (AW + 1)'(1);
        else if (!do_push && pop) count_d = count_q - (AW + 1)'(1);
        ovf_d = ovf_q;
        if (push_req && !do_push) ovf_d = 1'b1;
        else if (Ovf_Clr) ovf_d = 1'b0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            shift_q   <= 1'b0;
            caps_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            caps_q    <= caps_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_char;
    end

    assign Rd_Data     = rd_data_q;
    assign Empty       = (count_q == '0);
    assign Full        = (count_q == FULL_CNT);
    assign Overflow    = ovf_q;
    assign Shift_State = shift_q;
`ifdef KB_CAPS_LOCK_EN
    assign Caps_State  = caps_q;
`endif

endmodule
